// File: rtl/key_pkg.sv
// Shared key codes and ASCII byte constants for key_converter and the game control FSM.
package key_pkg;

    localparam logic [3:0] ZERO  = 4'd0;
    localparam logic [3:0] W     = 4'd1;
    localparam logic [3:0] A     = 4'd2;
    localparam logic [3:0] S     = 4'd3;
    localparam logic [3:0] D     = 4'd4;
    localparam logic [3:0] J     = 4'd5;
    localparam logic [3:0] K     = 4'd6;
    localparam logic [3:0] L     = 4'd7;
    localparam logic [3:0] SPACE = 4'd8;

    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_J     = 8'h4A;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [7:0] ASCII_LC_W = 8'h77;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_S = 8'h73;
    localparam logic [7:0] ASCII_LC_D = 8'h64;
    localparam logic [7:0] ASCII_LC_J = 8'h6A;
    localparam logic [7:0] ASCII_LC_K = 8'h6B;
    localparam logic [7:0] ASCII_LC_L = 8'h6C;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the keyboard byte, flagging when both stages agree.
module key_sync #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             stable
);

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Equal stages mean the byte survived at least two samples, so it is no glitch.
    assign dout   = sync2_q;
    assign stable = (sync1_q == sync2_q);

endmodule

// File: rtl/key_converter.sv
// Maps the synchronised ASCII keyboard byte to a registered 4-bit key code.
// Define KEY_CONVERTER_LOWERCASE_EN to also accept lowercase letters.
module key_converter
    import key_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keyboard,
    output logic [3:0] key
);

    logic [7:0] sync_byte;
    logic       stable;
    logic [3:0] key_d;
    logic [3:0] key_q;

    key_sync #(
        .Width (8)
    ) u_key_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (keyboard),
        .dout   (sync_byte),
        .stable (stable)
    );

    function automatic logic [3:0] decode(input logic [7:0] b);
        logic [3:0] code;
        code = ZERO;
        case (b)
            ASCII_W:     code = W;
            ASCII_A:     code = A;
            ASCII_S:     code = S;
            ASCII_D:     code = D;
            ASCII_J:     code = J;
            ASCII_K:     code = K;
            ASCII_L:     code = L;
            ASCII_SPACE: code = SPACE;
`ifdef KEY_CONVERTER_LOWERCASE_EN
            ASCII_LC_W:  code = W;
            ASCII_LC_A:  code = A;
            ASCII_LC_S:  code = S;
            ASCII_LC_D:  code = D;
            ASCII_LC_J:  code = J;
            ASCII_LC_K:  code = K;
            ASCII_LC_L:  code = L;
`endif
            default:     code = ZERO;
        endcase
        return code;
    endfunction

    always_comb begin
        key_d = key_q;
        if (stable) begin
            key_d = decode(sync_byte);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= ZERO;
        end else begin
            key_q <= key_d;
        end
    end

    assign key = key_q;

endmodule

// File: tb/tb_key_converter.sv
// Directed, table-driven bench for key_converter: decode map, latency, glitch and reset cases.
module tb_key_converter;

    logic       clk;
    logic       rst_n;
    logic [7:0] keyboard;
    logic [3:0] key;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] kb;
        logic [3:0] exp;
    } vec_t;

    localparam int NumVec = 22;
    vec_t vecs [NumVec];

    key_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .keyboard (keyboard),
        .key      (key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: key=%0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, hold for n rising edges, return 1 time unit after the last.
    task automatic apply(input logic [7:0] b, input int n);
        @(negedge clk);
        keyboard = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] lookup(input logic [7:0] b);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < NumVec; i++) begin
            if (vecs[i].kb == b) r = vecs[i].exp;
        end
        return r;
    endfunction

    initial begin
        logic [3:0] lc_w, lc_a, lc_s, lc_d, lc_j, lc_k, lc_l;
        logic [3:0] seq_exp [10];

        n_checks = 0;
        n_fail   = 0;

`ifdef KEY_CONVERTER_LOWERCASE_EN
        lc_w = 4'd1; lc_a = 4'd2; lc_s = 4'd3; lc_d = 4'd4;
        lc_j = 4'd5; lc_k = 4'd6; lc_l = 4'd7;
`else
        lc_w = 4'd0; lc_a = 4'd0; lc_s = 4'd0; lc_d = 4'd0;
        lc_j = 4'd0; lc_k = 4'd0; lc_l = 4'd0;
`endif
        vecs[0]  = '{8'h57, 4'd1};
        vecs[1]  = '{8'h41, 4'd2};
        vecs[2]  = '{8'h53, 4'd3};
        vecs[3]  = '{8'h44, 4'd4};
        vecs[4]  = '{8'h4A, 4'd5};
        vecs[5]  = '{8'h4B, 4'd6};
        vecs[6]  = '{8'h4C, 4'd7};
        vecs[7]  = '{8'h20, 4'd8};
        vecs[8]  = '{8'h77, lc_w};
        vecs[9]  = '{8'h61, lc_a};
        vecs[10] = '{8'h73, lc_s};
        vecs[11] = '{8'h64, lc_d};
        vecs[12] = '{8'h6A, lc_j};
        vecs[13] = '{8'h6B, lc_k};
        vecs[14] = '{8'h6C, lc_l};
        vecs[15] = '{8'h00, 4'd0};
        vecs[16] = '{8'hD7, 4'd0};
        vecs[17] = '{8'hC1, 4'd0};
        vecs[18] = '{8'hA0, 4'd0};
        vecs[19] = '{8'h17, 4'd0};
        vecs[20] = '{8'hFF, 4'd0};
        vecs[21] = '{8'h5F, 4'd0};

        // Reset asserted between edges with W already on the input.
        rst_n    = 1'b1;
        keyboard = 8'h57;
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", key, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", key, 4'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("latency_edge1", key, 4'd0);
        @(posedge clk); #1;
        check("latency_edge2", key, 4'd0);
        @(posedge clk); #1;
        check("latency_edge3", key, 4'd1);

        for (int i = 0; i < NumVec; i++) begin
            apply(vecs[i].kb, 4);
            check($sformatf("vec_%02h", vecs[i].kb), key, vecs[i].exp);
        end

        for (int b = 0; b < 256; b++) begin
            apply(8'(b), 4);
            check($sformatf("sweep_%02h", b), key, lookup(8'(b)));
        end

        // One-cycle D glitch inside a held S must never reach key.
        apply(8'h53, 4);
        check("glitch_pre", key, 4'd3);
        @(negedge clk);
        keyboard = 8'h44;
        @(negedge clk);
        keyboard = 8'h53;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("glitch_edge%0d", i), key, 4'd3);
        end

        // SPACE then J then idle, each byte for 3 edges; per-edge code trace.
        apply(8'h00, 4);
        check("seq_pre", key, 4'd0);
        seq_exp = '{4'd0, 4'd0, 4'd8, 4'd8, 4'd8, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0};
        @(negedge clk);
        keyboard = 8'h20;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("seq_edge%0d", i + 1), key, seq_exp[i]);
            @(negedge clk);
            if (i == 2) keyboard = 8'h4A;
            if (i == 5) keyboard = 8'h00;
        end

        // Short reset pulse between edges while K is held.
        apply(8'h4B, 4);
        check("rst_mid_pre", key, 4'd6);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", key, 4'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_edge1", key, 4'd0);
        @(posedge clk); #1;
        check("rst_mid_edge2", key, 4'd0);
        @(posedge clk); #1;
        check("rst_mid_edge3", key, 4'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
